// File: rtl/lag_counter.sv
// lag_counter: flash-to-sensor input lag meter in 0.1 ms BCD ticks.
// Keeps last/min/max/sample statistics for the text overlay.
module lag_counter #(
  parameter int TICK_DIV           = 14850,
  parameter bit SENSOR_ACTIVE_HIGH = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        starttrigger,
  input  logic        sensor,
  input  logic        clear_stats,
  output logic [79:0] bcdcount,
  output logic        measuring,
  output logic        result_valid,
  output logic        timeout
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] MEASURING = 1'b1;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [0:0]    state;
  logic          sync1;
  logic          sync2;
  logic          sens_s;
  logic [PW-1:0] prescaler;
  logic [15:0]   running;
  logic [15:0]   last;
  logic [15:0]   min_v;
  logic [15:0]   max_v;
  logic [15:0]   samples;

  logic wrap;
  logic arm;
  logic detect;
  logic expire;
  logic count;

  // Four-digit packed BCD increment with ripple carry.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign sens_s = SENSOR_ACTIVE_HIGH ? sync2 : ~sync2;

  assign wrap   = (state == MEASURING) && (prescaler == PS_LAST);
  assign arm    = (state == IDLE) && starttrigger && !sens_s;
  assign detect = (state == MEASURING) && sens_s;
  assign expire = wrap && (running == 16'h9999) && !sens_s;
  assign count  = (state == MEASURING) && !detect && !expire;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      prescaler    <= '0;
      running      <= 16'h0000;
      last         <= 16'h0000;
      min_v        <= 16'h9999;
      max_v        <= 16'h0000;
      samples      <= 16'h0000;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      sync1        <= sensor;
      sync2        <= sync1;
      result_valid <= detect;

      unique case (1'b1)
        arm: begin
          state     <= MEASURING;
          running   <= 16'h0000;
          prescaler <= '0;
          timeout   <= 1'b0;
        end
        detect: begin
          state <= IDLE;
          last  <= running;
          if (running < min_v) min_v <= running;
          if (running > max_v) max_v <= running;
          if (samples != 16'h9999) samples <= bcd_inc(samples);
        end
        expire: begin
          state   <= IDLE;
          timeout <= 1'b1;
          last    <= 16'h9999;
        end
        count: begin
          if (wrap) begin
            prescaler <= '0;
            running   <= bcd_inc(running);
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        default: ;
      endcase

      // Clearing overrides a sample recorded in the same cycle.
      if (clear_stats) begin
        last    <= 16'h0000;
        min_v   <= 16'h9999;
        max_v   <= 16'h0000;
        samples <= 16'h0000;
      end
    end
  end

  assign measuring = state;
  assign bcdcount  = {running, last, min_v, max_v, samples};

endmodule

// File: tb/tb_lag_counter.sv
// tb_lag_counter: directed checks of lag_counter with TICK_DIV=4.
// Expected bus values are hand-computed BCD statistics.
module tb_lag_counter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        starttrigger = 1'b0;
  logic        sensor = 1'b0;
  logic        clear_stats = 1'b0;
  logic [79:0] bcdcount;
  logic        measuring;
  logic        result_valid;
  logic        timeout;

  int passed = 0;
  int total  = 0;

  localparam logic [79:0] RST_BUS = 80'h0000_0000_9999_0000_0000;

  lag_counter #(
    .TICK_DIV(4),
    .SENSOR_ACTIVE_HIGH(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .starttrigger(starttrigger),
    .sensor(sensor),
    .clear_stats(clear_stats),
    .bcdcount(bcdcount),
    .measuring(measuring),
    .result_valid(result_valid),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pulse_trigger();
    starttrigger = 1'b1;
    tick();
    starttrigger = 1'b0;
  endtask

  // Called in cycle S: raise sensor, wait for the sample at S+3.
  task automatic finish_sample(input bit clr, input logic [79:0] exp,
                               input string tag);
    sensor = 1'b1;
    tick();
    tick();
    clear_stats = clr;
    tick();
    clear_stats = 1'b0;
    chk({tag, "_rv"}, 80'(result_valid), 80'd1);
    chk({tag, "_meas"}, 80'(measuring), 80'd0);
    chk({tag, "_bus"}, bcdcount, exp);
    sensor = 1'b0;
    tick();
    chk({tag, "_rv_end"}, 80'(result_valid), 80'd0);
    tick();
    tick();
  endtask

  // Sensor at S = T + 4n so the sample reads running = n.
  task automatic measure(input int n, input bit clr,
                         input logic [79:0] exp, input string tag);
    pulse_trigger();
    repeat (4 * n - 1) tick();
    finish_sample(clr, exp, tag);
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_bus", bcdcount, RST_BUS);
    chk("rst_meas", 80'(measuring), 80'd0);
    chk("rst_rv", 80'(result_valid), 80'd0);
    chk("rst_to", 80'(timeout), 80'd0);

    pulse_trigger();
    chk("arm_meas", 80'(measuring), 80'd1);
    chk("arm_run", 80'(bcdcount[79:64]), 80'h0000);
    repeat (4) tick();
    chk("first_tick", 80'(bcdcount[79:64]), 80'h0001);
    repeat (4 * 37 - 1 - 4) tick();
    finish_sample(1'b0, 80'h0037_0037_0037_0037_0001, "s37");

    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clr_bus", bcdcount, 80'h0037_0000_9999_0000_0000);
    chk("clr_meas", 80'(measuring), 80'd0);

    pulse_trigger();
    repeat (36) tick();
    chk("run_9", 80'(bcdcount[79:64]), 80'h0009);
    repeat (4) tick();
    chk("run_10", 80'(bcdcount[79:64]), 80'h0010);
    repeat (7) tick();
    finish_sample(1'b0, 80'h0012_0012_0012_0012_0001, "s12");
    measure(5, 1'b0, 80'h0005_0005_0005_0012_0002, "s5");
    measure(30, 1'b0, 80'h0030_0030_0005_0030_0003, "s30");

    sensor = 1'b1;
    repeat (3) tick();
    pulse_trigger();
    chk("ign_meas", 80'(measuring), 80'd0);
    tick();
    chk("ign_rv", 80'(result_valid), 80'd0);
    chk("ign_bus", bcdcount, 80'h0030_0030_0005_0030_0003);
    sensor = 1'b0;
    repeat (3) tick();

    pulse_trigger();
    repeat (39999) tick();
    chk("pre_to_meas", 80'(measuring), 80'd1);
    chk("pre_to_run", 80'(bcdcount[79:64]), 80'h9999);
    tick();
    chk("to_flag", 80'(timeout), 80'd1);
    chk("to_meas", 80'(measuring), 80'd0);
    chk("to_rv", 80'(result_valid), 80'd0);
    chk("to_bus", bcdcount, 80'h9999_9999_0005_0030_0003);
    tick();
    chk("to_hold", 80'(timeout), 80'd1);

    pulse_trigger();
    chk("rearm_to", 80'(timeout), 80'd0);
    chk("rearm_meas", 80'(measuring), 80'd1);
    chk("rearm_run", 80'(bcdcount[79:64]), 80'h0000);
    repeat (8) tick();
    pulse_trigger();
    chk("retrig_run", 80'(bcdcount[79:64]), 80'h0002);
    chk("retrig_meas", 80'(measuring), 80'd1);
    finish_sample(1'b0, 80'h0002_0002_0002_0030_0004, "s2");

    measure(3, 1'b1, 80'h0003_0000_9999_0000_0000, "clr_det");
    measure(7, 1'b0, 80'h0007_0007_0007_0007_0001, "s7");

    pulse_trigger();
    repeat (492) tick();
    chk("run_123", 80'(bcdcount[79:64]), 80'h0123);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_bus", bcdcount, RST_BUS);
    chk("mid_rst_meas", 80'(measuring), 80'd0);
    chk("mid_rst_rv", 80'(result_valid), 80'd0);
    repeat (3) tick();
    chk("mid_rst_idle", 80'(measuring), 80'd0);

    force dut.samples = 16'h9998;
    tick();
    release dut.samples;
    tick();
    chk("preload", 80'(bcdcount[15:0]), 80'h9998);
    measure(1, 1'b0, 80'h0001_0001_0001_0001_9999, "sat_a");
    measure(2, 1'b0, 80'h0002_0002_0001_0002_9999, "sat_b");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
